aes_iter_core: RTL



---
 rtl/aes_pkg.sv | 90 +++++++++
 rtl/aes_key_step.sv | 29 ++
 rtl/aes_iter_core.sv | 97 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, S-box, Rcon, round functions
// and FSM encoding used by the iterative core and its key-schedule step.
package aes_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as inverse (x^254) followed by the affine map, so there
  // is no 256-entry table to transcribe.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, b;
    r = x;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), x);
    b = gmul(r, r);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < 10; k++)
      if (k < int'(idx)) r = xtime(r);
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk);
    return mix_columns(shift_rows(sub_bytes(s))) ^ rk;
  endfunction

  function automatic logic [127:0] aes_last_round(input logic [127:0] s, input logic [127:0] rk);
    return shift_rows(sub_bytes(s)) ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-schedule step: derives the next four words from the previous NK
// words (word 0 = oldest, at the MSB end).
module aes_key_step
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] prev,
  input  logic             rot_rcon,
  input  logic [7:0]       rcon_byte,
  output logic [127:0]     next
);

  logic [31:0] last_w, t_w, w;

  always_comb begin
    last_w = prev[31:0];
    t_w    = rot_rcon ? (sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon_byte, 24'h0})
                      : sub_word(last_w);
    next   = '0;
    w      = t_w;
    // w[i+j] = w[i+j-NK] ^ (j==0 ? f(w[i-1]) : w[i+j-1])
    for (int j = 0; j < 4; j++) begin
      w = prev[32*NK-1-32*j -: 32] ^ w;
      next[127-32*j -: 32] = w;
    end
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryptor: one round per clock, key schedule
// expanded on the fly from a sliding window of the last NK words.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy
);

  localparam int NR = nr_of(KEY_BITS);
  localparam int NK = KEY_BITS / 32;

  logic [1:0]          fsm;
  logic [3:0]          rnd;
  logic [127:0]        state;
  logic [KEY_BITS-1:0] win;
  logic [KEY_BITS-1:0] win_next;
  logic [127:0]        step_out, round_key;
  logic                step_rot;
  logic [3:0]          rcon_idx;

  // In round r the 128-bit window holds rk[r-1]; the 256-bit window holds
  // {rk[r-1], rk[r]} and generates rk[r+1].
  generate
    if (KEY_BITS == 256) begin : g_k256
      assign step_rot  = rnd[0];
      assign rcon_idx  = (rnd + 4'd1) >> 1;
      assign round_key = win[127:0];
      assign win_next  = {win[127:0], step_out};
    end else if (KEY_BITS == 128) begin : g_k128
      assign step_rot  = 1'b1;
      assign rcon_idx  = rnd;
      assign round_key = step_out;
      assign win_next  = step_out;
    end else begin : g_bad
      $error("aes_iter_core: KEY_BITS must be 128 or 256");
    end
  endgenerate

  aes_key_step #(.NK(NK)) u_key_step (
    .prev      (win),
    .rot_rcon  (step_rot),
    .rcon_byte (rcon(rcon_idx)),
    .next      (step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state     <= '0;
      win       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state <= in_data ^ in_key[KEY_BITS-1 -: 128];
          win   <= in_key;
          rnd   <= 4'd1;
          fsm   <= ROUND;
        end
        ROUND: begin
          win <= win_next;
          if (rnd == 4'(NR)) begin
            out_data  <= aes_last_round(state, round_key);
            out_valid <= 1'b1;
            rnd       <= '0;
            fsm       <= DONE;
          end else begin
            state <= aes_round(state, round_key);
            rnd   <= rnd + 4'd1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready = (fsm == IDLE);
  assign busy     = (fsm == ROUND) || (fsm == DONE);

endmodule
